// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and geometry for the L1 I-cache refill path.
// Constants track SIZE_PC and CACHE_WIDTH so the cache and refill logic agree.
package icache_refill_ctrl_pkg;

  localparam int SIZE_PC     = 32;
  localparam int CACHE_WIDTH = 256;

  localparam int ADDR_W = SIZE_PC;
  localparam int LINE_W = CACHE_WIDTH;
  localparam int BEAT_W = 64;
  localparam int BEATS  = LINE_W / BEAT_W;
  localparam int OFFS_W = $clog2(LINE_W / 8);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    FILL   = 3'd2,
    WRITE  = 3'd3,
    SETTLE = 3'd4
  } refill_state_e;

endpackage

// File: rtl/icache_refill_ctrl_line_buffer.sv
// Beat counter plus line assembly register for the refill path.
// Beat n lands in bits [n*BEAT_W +: BEAT_W]; full flags the last beat slot.
module refill_line_buffer
  import icache_refill_ctrl_pkg::*;
#(
  parameter int BW = icache_refill_ctrl_pkg::BEAT_W,
  parameter int NB = icache_refill_ctrl_pkg::BEATS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             beatWr,
  input  logic [BW-1:0]    beat,
  output logic             full,
  output logic [NB*BW-1:0] line
);

  localparam int CNT_W = $clog2(NB);

  logic [CNT_W-1:0]          cnt;
  logic [NB-1:0][BW-1:0]     lineQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (beatWr) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lineQ <= '0;
    end else if (beatWr) begin
      for (int g = 0; g < NB; g++)
        if (cnt == CNT_W'(g)) lineQ[g] <= beat;
    end
  end

  assign full = (cnt == CNT_W'(NB - 1));
  assign line = lineQ;

endmodule

// File: rtl/icache_refill_ctrl.sv
// L1 I-cache miss handler: one line request, beat collection, one-cycle write.
// Define ICACHE_REFILL_PERF_EN to add refill/stall performance counters.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W = icache_refill_ctrl_pkg::ADDR_W,
  parameter int LINE_W = icache_refill_ctrl_pkg::LINE_W,
  parameter int BEAT_W = icache_refill_ctrl_pkg::BEAT_W,
  parameter int BEATS  = icache_refill_ctrl_pkg::BEATS,
  parameter int OFFS_W = icache_refill_ctrl_pkg::OFFS_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              miss_i,
  input  logic [ADDR_W-1:0] missAddr_i,
  input  logic              flush_i,
  output logic              memReq_o,
  output logic [ADDR_W-1:0] memAddr_o,
  input  logic              memReqAck_i,
  input  logic              memBeatValid_i,
  input  logic [BEAT_W-1:0] memBeat_i,
  output logic              wrEnable_o,
  output logic [ADDR_W-1:0] wrAddr_o,
  output logic [LINE_W-1:0] instBlock_o,
  output logic              busy_o
`ifdef ICACHE_REFILL_PERF_EN
  ,
  output logic [31:0]       refillCount_o,
  output logic [31:0]       refillStallCycles_o
`endif
);

  refill_state_e     state, nextState;
  logic [ADDR_W-1:0] lineAddr, missLine;
  logic              acceptMiss, beatWr, bufClear, bufFull;
  logic              memReqNext, wrEnNext, busyNext;
  logic              unusedOffs;

  assign missLine   = {missAddr_i[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
  assign unusedOffs = ^missAddr_i[OFFS_W-1:0];

  // SETTLE is excluded here: the lookup that raised miss_i predates the write.
  assign acceptMiss = (state == IDLE) && miss_i && !flush_i;
  assign beatWr     = (state == FILL) && memBeatValid_i;
  assign bufClear   = (state == REQ) && memReqAck_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:   if (acceptMiss) nextState = REQ;
      // An ack in the same cycle as a flush wins: the request is already taken.
      REQ:    if (memReqAck_i)  nextState = FILL;
              else if (flush_i) nextState = IDLE;
      FILL:   if (beatWr && bufFull) nextState = WRITE;
      WRITE:  nextState = SETTLE;
      SETTLE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    memReqNext = (nextState == REQ);
    wrEnNext   = (nextState == WRITE);
    busyNext   = (nextState != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memReq_o   <= 1'b0;
      wrEnable_o <= 1'b0;
      busy_o     <= 1'b0;
      wrAddr_o   <= '0;
      lineAddr   <= '0;
    end else begin
      memReq_o   <= memReqNext;
      wrEnable_o <= wrEnNext;
      busy_o     <= busyNext;
      if (acceptMiss) lineAddr <= missLine;
      if (wrEnNext)   wrAddr_o <= lineAddr;
    end
  end

  assign memAddr_o = lineAddr;

  refill_line_buffer #(
    .BW (BEAT_W),
    .NB (BEATS)
  ) u_lineBuf (
    .clk    (clk),
    .reset  (reset),
    .clear  (bufClear),
    .beatWr (beatWr),
    .beat   (memBeat_i),
    .full   (bufFull),
    .line   (instBlock_o)
  );

`ifdef ICACHE_REFILL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refillCount_o       <= '0;
      refillStallCycles_o <= '0;
    end else begin
      if (state == WRITE && refillCount_o != '1)
        refillCount_o <= refillCount_o + 32'd1;
      if (busy_o && refillStallCycles_o != '1)
        refillStallCycles_o <= refillStallCycles_o + 32'd1;
    end
  end
`endif

endmodule
